// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage constants: FSM state encodings, reset PC default and PC step.
package instruction_fetch_pkg;

    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_WAIT = 3'd1,
        S_HOLD = 3'd2,
        S_DROP = 3'd3,
        S_HALT = 3'd4
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch FSM, plus detection of misaligned redirect targets.
module fetch_next_pc
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      state,
    input  logic [XLEN-1:0] pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt_req,
    input  logic            inst_ready,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    always_comb begin
        misaligned = redirect_valid && is_misaligned(redirect_pc[1:0]) && (state != S_HALT);
        next_pc    = pc;
        if (!misaligned) begin
            case (state)
                // A halt seen while requesting outranks a simultaneous redirect.
                S_REQ: begin
                    if (redirect_valid && !halt_req) next_pc = redirect_pc;
                end
                S_WAIT, S_DROP: begin
                    if (redirect_valid) next_pc = redirect_pc;
                end
                S_HOLD: begin
                    if (redirect_valid) next_pc = redirect_pc;
                    else if (inst_ready) next_pc = pc + XLEN'(PC_INC);
                end
                default: next_pc = pc;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem request, holds the returned word for decode,
// and handles redirects, halt and misaligned-target faults.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            halted,
    output logic            misaligned_fault
);

    fetch_state_t    state;
    fetch_state_t    reenter;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;
    logic            halt_pend;
    logic            halt_eff;
    logic            fault;

    assign halt_eff = halt | halt_pend;
    // Every return to S_REQ diverts to S_HALT once a halt has been seen.
    assign reenter  = halt_eff ? S_HALT : S_REQ;

    fetch_next_pc #(
        .XLEN(XLEN)
    ) u_next_pc (
        .state         (state),
        .pc            (pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halt_req      (halt_eff),
        .inst_ready    (inst_ready),
        .next_pc       (next_pc),
        .misaligned    (misaligned)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            inst_out  <= '0;
            inst_pc   <= '0;
            fault     <= 1'b0;
            halt_pend <= 1'b0;
        end else begin
            pc <= next_pc;
            if (misaligned) fault <= 1'b1;
            if (halt && state != S_HALT) halt_pend <= 1'b1;
            if (misaligned) begin
                state <= S_HALT;
            end else begin
                case (state)
                    S_REQ: begin
                        if (halt_eff) state <= imem_req_ready ? S_DROP : S_HALT;
                        else if (imem_req_ready) state <= redirect_valid ? S_DROP : S_WAIT;
                    end
                    S_WAIT: begin
                        if (imem_resp_valid) begin
                            if (redirect_valid) begin
                                state <= reenter;
                            end else begin
                                inst_out <= imem_resp_data;
                                inst_pc  <= pc;
                                state    <= S_HOLD;
                            end
                        end else if (redirect_valid) begin
                            state <= S_DROP;
                        end
                    end
                    S_HOLD: begin
                        if (redirect_valid || inst_ready) state <= reenter;
                    end
                    S_DROP: begin
                        if (imem_resp_valid) state <= reenter;
                    end
                    S_HALT: state <= S_HALT;
                    default: state <= S_REQ;
                endcase
            end
        end
    end

    assign imem_req_valid   = reset_n && (state == S_REQ);
    assign imem_req_addr    = pc;
    assign inst_valid       = reset_n && (state == S_HOLD);
    assign halted           = reset_n && (state == S_HALT);
    assign misaligned_fault = fault;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: two instances (RESET_PC 0 and 0xFFFF_FFFC),
// bench-side memory models, expected requests and deliveries queued by the stimulus.
module tb_instruction_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: RESET_PC = 0
    logic        reset_n = 1'b0;
    logic        req_valid_a, inst_valid_a, halted_a, fault_a;
    logic        mem_ready_a = 1'b1;
    logic [31:0] req_addr_a, inst_out_a, inst_pc_a;
    logic        resp_valid_a = 1'b0;
    logic [31:0] resp_data_a = 32'h0;
    logic        inst_ready_a = 1'b0;
    logic        redirect_valid_a = 1'b0;
    logic [31:0] redirect_pc_a = 32'h0;
    logic        halt_a = 1'b0;

    // Instance B: RESET_PC = 0xFFFF_FFFC, memory always ready
    logic        reset_b = 1'b0;
    logic        req_valid_b, inst_valid_b, halted_b, fault_b;
    logic        req_ready_b = 1'b1;
    logic [31:0] req_addr_b, inst_out_b, inst_pc_b;
    logic        resp_valid_b = 1'b0;
    logic [31:0] resp_data_b = 32'h0;
    logic        inst_ready_b = 1'b0;
    logic        redirect_valid_b = 1'b0;
    logic [31:0] redirect_pc_b = 32'h0;
    logic        halt_b = 1'b0;

    instruction_fetch #(
        .XLEN    (32),
        .RESET_PC(32'h0000_0000)
    ) dut_a (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_req_valid  (req_valid_a),
        .imem_req_ready  (mem_ready_a),
        .imem_req_addr   (req_addr_a),
        .imem_resp_valid (resp_valid_a),
        .imem_resp_data  (resp_data_a),
        .inst_valid      (inst_valid_a),
        .inst_ready      (inst_ready_a),
        .inst_out        (inst_out_a),
        .inst_pc         (inst_pc_a),
        .redirect_valid  (redirect_valid_a),
        .redirect_pc     (redirect_pc_a),
        .halt            (halt_a),
        .halted          (halted_a),
        .misaligned_fault(fault_a)
    );

    instruction_fetch #(
        .XLEN    (32),
        .RESET_PC(32'hFFFF_FFFC)
    ) dut_b (
        .clk             (clk),
        .reset_n         (reset_b),
        .imem_req_valid  (req_valid_b),
        .imem_req_ready  (req_ready_b),
        .imem_req_addr   (req_addr_b),
        .imem_resp_valid (resp_valid_b),
        .imem_resp_data  (resp_data_b),
        .inst_valid      (inst_valid_b),
        .inst_ready      (inst_ready_b),
        .inst_out        (inst_out_b),
        .inst_pc         (inst_pc_b),
        .redirect_valid  (redirect_valid_b),
        .redirect_pc     (redirect_pc_b),
        .halt            (halt_b),
        .halted          (halted_b),
        .misaligned_fault(fault_b)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    int total = 0;
    int bad   = 0;
    int n_req = 0;
    int n_inst = 0;
    int req_t[$];
    logic [31:0] exp_req[$];
    logic [31:0] exp_pc[$];
    logic [31:0] exp_data[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string detail);
        total++;
        bad++;
        $display("FAIL %s: %s", name, detail);
    endtask

    // Memory model A: response imem_delay cycles after acceptance.
    int          mem_delay_a = 1;
    int          cnt_a = 0;
    logic        pend_a = 1'b0;
    logic [31:0] addr_a = 32'h0;
    always @(negedge clk) begin
        resp_valid_a = 1'b0;
        resp_data_a  = 32'hDEAD_BEEF;
        if (!reset_n) begin
            pend_a = 1'b0;
        end else begin
            if (pend_a) begin
                if (cnt_a <= 1) begin
                    resp_valid_a = 1'b1;
                    resp_data_a  = mem_word(addr_a);
                    pend_a       = 1'b0;
                end else begin
                    cnt_a--;
                end
            end
            if (req_valid_a && mem_ready_a) begin
                pend_a = 1'b1;
                cnt_a  = mem_delay_a;
                addr_a = req_addr_a;
            end
        end
    end

    // Memory model B: fixed one-cycle response.
    logic        pend_b = 1'b0;
    logic [31:0] addr_b = 32'h0;
    always @(negedge clk) begin
        resp_valid_b = 1'b0;
        resp_data_b  = 32'hDEAD_BEEF;
        if (!reset_b) begin
            pend_b = 1'b0;
        end else begin
            if (pend_b) begin
                resp_valid_b = 1'b1;
                resp_data_b  = mem_word(addr_b);
            end
            pend_b = req_valid_b && req_ready_b;
            addr_b = req_addr_b;
        end
    end

    task automatic mon_req(input logic [31:0] addr);
        n_req++;
        req_t.push_back(cyc);
        if (exp_req.size() == 0) fail("req_unexpected", $sformatf("got addr %h required none", addr));
        else check("req_addr", addr, exp_req.pop_front());
    endtask

    task automatic mon_inst(input logic [31:0] pc, input logic [31:0] data);
        n_inst++;
        if (exp_pc.size() == 0) begin
            fail("inst_unexpected", $sformatf("got pc %h data %h required none", pc, data));
        end else begin
            check("inst_pc", pc, exp_pc.pop_front());
            check("inst_data", data, exp_data.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && req_valid_a && mem_ready_a) mon_req(req_addr_a);
        if (reset_n && inst_valid_a && inst_ready_a && !redirect_valid_a)
            mon_inst(inst_pc_a, inst_out_a);
        if (reset_b && req_valid_b && req_ready_b) mon_req(req_addr_b);
        if (reset_b && inst_valid_b && inst_ready_b && !redirect_valid_b)
            mon_inst(inst_pc_b, inst_out_b);
    end

    task automatic push_inst(input logic [31:0] pc);
        exp_pc.push_back(pc);
        exp_data.push_back(mem_word(pc));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int target, input string name);
        int k = 0;
        while (n_req < target && k < 40) begin tick(); k++; end
        if (n_req < target) fail(name, $sformatf("timed out, got %0d requests required %0d", n_req, target));
    endtask

    task automatic wait_inst(input int target, input string name);
        int k = 0;
        while (n_inst < target && k < 40) begin tick(); k++; end
        if (n_inst < target) fail(name, $sformatf("timed out, got %0d insts required %0d", n_inst, target));
    endtask

    task automatic wait_valid_a(input string name);
        int k = 0;
        while (!inst_valid_a && k < 40) begin tick(); k++; end
        if (!inst_valid_a) fail(name, "timed out, inst_valid 0 required 1");
    endtask

    task automatic wait_halted_b(input string name);
        int k = 0;
        while (!halted_b && k < 40) begin tick(); k++; end
        if (!halted_b) fail(name, "timed out, halted 0 required 1");
    endtask

    initial begin
        repeat (2) tick();
        check("rst_req_valid", {31'd0, req_valid_a}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid_a}, 32'd0);
        check("rst_halted", {31'd0, halted_a}, 32'd0);
        check("rst_inst_out", inst_out_a, 32'h0);
        check("rst_inst_pc", inst_pc_a, 32'h0);
        check("rst_fault", {31'd0, fault_a}, 32'd0);
        check("rst_addr", req_addr_a, 32'h0);

        // Streaming at 1 instruction per 3 cycles
        exp_req.push_back(32'h0);
        exp_req.push_back(32'h4);
        exp_req.push_back(32'h8);
        exp_req.push_back(32'hC);
        push_inst(32'h0);
        push_inst(32'h4);
        push_inst(32'h8);
        inst_ready_a = 1'b1;
        reset_n = 1'b1;
        wait_inst(3, "stream_timeout");
        inst_ready_a = 1'b0;
        if (req_t.size() >= 3) begin
            check("gap_0_1", 32'(req_t[1] - req_t[0]), 32'd3);
            check("gap_1_2", 32'(req_t[2] - req_t[1]), 32'd3);
        end else begin
            fail("gap", $sformatf("got %0d requests required 3", req_t.size()));
        end

        // Decode back-pressure: instruction held, no new request
        wait_valid_a("hold_timeout");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", {31'd0, inst_valid_a}, 32'd1);
            check("hold_pc", inst_pc_a, 32'hC);
            check("hold_data", inst_out_a, mem_word(32'hC));
            check("hold_no_req", {31'd0, req_valid_a}, 32'd0);
        end
        push_inst(32'hC);
        exp_req.push_back(32'h10);
        mem_delay_a  = 3;
        inst_ready_a = 1'b1;
        wait_req(5, "req10_timeout");

        // Redirect while waiting: late response for 0x10 must be dropped
        inst_ready_a = 1'b0;
        redirect_valid_a = 1'b1;
        redirect_pc_a = 32'h100;
        exp_req.push_back(32'h100);
        tick();
        redirect_valid_a = 1'b0;
        wait_valid_a("redir_wait_timeout");
        check("redir_wait_pc", inst_pc_a, 32'h100);
        check("redir_wait_data", inst_out_a, mem_word(32'h100));

        // Redirect while holding with inst_ready high: held word not consumed
        mem_delay_a = 1;
        exp_req.push_back(32'h200);
        inst_ready_a = 1'b1;
        redirect_valid_a = 1'b1;
        redirect_pc_a = 32'h200;
        tick();
        redirect_valid_a = 1'b0;
        inst_ready_a = 1'b0;
        check("redir_hold_drop", {31'd0, inst_valid_a}, 32'd0);
        wait_valid_a("redir_hold_timeout");
        check("redir_hold_pc", inst_pc_a, 32'h200);
        check("redir_hold_data", inst_out_a, mem_word(32'h200));
        check("redir_hold_count", 32'(n_inst), 32'd4);

        // Misaligned redirect: sticky fault and halt until reset
        redirect_valid_a = 1'b1;
        redirect_pc_a = 32'h102;
        tick();
        redirect_valid_a = 1'b0;
        check("mis_fault", {31'd0, fault_a}, 32'd1);
        check("mis_halted", {31'd0, halted_a}, 32'd1);
        check("mis_inst_valid", {31'd0, inst_valid_a}, 32'd0);
        inst_ready_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mis_no_req", {31'd0, req_valid_a}, 32'd0);
            check("mis_stay_halted", {31'd0, halted_a}, 32'd1);
        end
        reset_n = 1'b0;
        #1;
        check("rst2_halted_gated", {31'd0, halted_a}, 32'd0);
        tick();
        check("rst2_fault", {31'd0, fault_a}, 32'd0);
        check("rst2_addr", req_addr_a, 32'h0);
        exp_req.push_back(32'h0);
        reset_n = 1'b1;
        wait_req(8, "rst2_req_timeout");
        reset_n = 1'b0;
        inst_ready_a = 1'b0;

        // Instance B: PC wraps, then halt sampled while waiting
        exp_req.push_back(32'hFFFF_FFFC);
        exp_req.push_back(32'h0);
        push_inst(32'hFFFF_FFFC);
        inst_ready_b = 1'b1;
        tick();
        reset_b = 1'b1;
        wait_req(10, "wrap_timeout");
        check("wrap_inst_count", 32'(n_inst), 32'd5);
        push_inst(32'h0);
        halt_b = 1'b1;
        tick();
        halt_b = 1'b0;
        wait_halted_b("halt_timeout");
        check("halt_delivered", 32'(n_inst), 32'd6);
        check("halt_inst_valid", {31'd0, inst_valid_b}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("halt_no_req", {31'd0, req_valid_b}, 32'd0);
            check("halt_stays", {31'd0, halted_b}, 32'd1);
        end

        check("req_queue_empty", 32'(exp_req.size()), 32'd0);
        check("inst_queue_empty", 32'(exp_pc.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage: holds the PC, issues one request at a time to instruction memory through a valid/ready handshake, and presents the returned 32-bit instruction with its PC to decode.
- Decode slices the instruction into the immediate generator and register file.
- Accepts a redirect from execute (branch/JAL/JALR target), discarding any younger instruction or in-flight response.
- Accepts a halt (ECALL).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
XLEN, 32, address/instruction width (only 32 supported)

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  synchronous, active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  XLEN  request address (= PC)
imem_resp_valid  input  1  response data valid; arrives >=1 cycle after acceptance
imem_resp_data  input  XLEN  fetched instruction
inst_valid  output  1  instruction to decode valid
inst_ready  input  1  decode consumes instruction this cycle
inst_out  output  XLEN  instruction word
inst_pc  output  XLEN  PC of inst_out
redirect_valid  input  1  execute requests PC change
redirect_pc  input  XLEN  new PC
halt  input  1  stop fetching (ECALL retired)
halted  output  1  fetch stopped
misaligned_fault  output  1  sticky, redirect_pc[1:0] != 0 seen

Behaviour:
- Reset (reset_n=0 at clk edge): pc=RESET_PC, state=S_REQ, inst_out=0, inst_pc=0, fault=0. During any cycle with reset_n=0: imem_req_valid=0, inst_valid=0, halted=0. Reset mid-transaction abandons it; memory is reset together with fetch.
- Outputs from state: imem_req_valid=(state==S_REQ), imem_req_addr=pc, inst_valid=(state==S_HOLD), halted=(state==S_HALT).
- States and priority per cycle: misaligned redirect > halt > redirect > normal.
- S_REQ: handshake (req_ready) -> S_WAIT. Redirect without handshake: pc<=redirect_pc, stay. Redirect with handshake: pc<=redirect_pc, -> S_DROP. halt without handshake -> S_HALT. halt with handshake -> S_DROP then S_HALT after the response.
- S_WAIT: resp_valid -> inst_out<=resp_data, inst_pc<=pc, -> S_HOLD. Redirect without resp: pc<=redirect_pc, -> S_DROP. Redirect with resp: response discarded, pc<=redirect_pc, -> S_REQ.
- S_HOLD: inst_ready without redirect: pc<=pc+4, -> S_REQ. Redirect: instruction dropped even if inst_ready=1, pc<=redirect_pc, -> S_REQ. inst_out/inst_pc stable while held.
- S_DROP: resp_valid discarded, -> S_REQ (or S_HALT if halt pending). Redirect here updates pc, stays until response.
- S_HALT: terminal until reset. Ignores resp_valid, redirect, inst_ready.
- halt is a level input. Sampling it in S_WAIT/S_HOLD takes effect at the next S_REQ entry via a pending flag, which is cleared by reset.
- redirect_pc[1:0]!=0 in any non-halt state: fault<=1 (sticky), pc unchanged, -> S_HALT. An outstanding response is ignored.
- pc+4 is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- resp_valid in S_REQ/S_HALT is ignored (protocol violation, no state change).
- Latency: with zero-wait memory and inst_ready=1, request accepted cycle n, response n+1, inst_valid n+2, next request n+3. Throughput 1 instruction per 3 cycles. One outstanding request maximum.

Decomposition:
- Shared constants header: state encodings (S_REQ, S_WAIT, S_HOLD, S_DROP, S_HALT, 3 bits), RESET_PC default, PC_INC=4.
- One combinational sub-module, fetch_next_pc: pc, redirect, handshake and state -> next pc and fault detect.
- FSM and registers stay in instruction_fetch.

Test Plan:
- Reset release, memory ready=1, 1-cycle response, inst_ready=1 -> addr 0x0, 0x4, 0x8 at cycles 0/3/6. inst_valid with inst_pc 0x0/0x4/0x8, data passed through.
- inst_ready=0 for 5 cycles in S_HOLD -> inst_valid stays 1, inst_out/inst_pc stable, no new request. Release -> next addr=pc+4.
- Redirect to 0x100 in S_WAIT, response 3 cycles later -> response discarded, next request addr=0x100, no inst_valid for old data.
- Redirect to 0x200 in S_HOLD with inst_ready=1 same cycle -> held instruction not consumed, next addr=0x200.
- Redirect to 0x102 -> misaligned_fault=1, halted=1 next cycle, no further requests until reset_n=0. Reset then clears both and first addr=RESET_PC.
- RESET_PC=32'hFFFF_FFFC, consume one instruction -> next addr 0x0. halt asserted in S_WAIT -> response delivered, then halted=1 and req_valid=0.
